// File: rtl/t2mi_to_ts_packer.sv
// Packs a T2-MI byte stream into 188-byte MPEG-TS packets on a single PID.
// Define TS_NULL_FILL_EN to emit null packets when the upstream starves.
module t2mi_to_ts_packer #(
    parameter logic [12:0] PID          = 13'h1000,
    parameter int unsigned NULL_TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DATA_IN,
    input  logic       ENA_IN,
    input  logic [7:0] POINTER_IN,
    output logic       UP_ENA,
    output logic [7:0] TS_DATA,
    output logic       TS_VALID,
    output logic       TS_SOP,
    input  logic       OUT_READY,
    output logic [3:0] cc_mon
);

    localparam logic [2:0] StWait = 3'd0;
    localparam logic [2:0] StHdr  = 3'd1;
    localparam logic [2:0] StPtr  = 3'd2;
    localparam logic [2:0] StPay  = 3'd3;
`ifdef TS_NULL_FILL_EN
    localparam logic [2:0] StNull = 3'd4;
`endif

    logic [2:0]  state_q, state_d;
    logic [7:0]  p_q, p_d;
    logic        pusi_q, pusi_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  cc_q, cc_d;
    logic [7:0]  ts_data_q, ts_data_d;
    logic        ts_valid_q, ts_valid_d;
    logic        ts_sop_q, ts_sop_d;
    logic [15:0] starve_q, starve_d;

    logic        slot_free;
    logic        up_ena;
    logic        starve_hit;
    logic [7:0]  hdr_byte;

    assign slot_free  = !ts_valid_q || OUT_READY;
    assign starve_hit = (starve_q == 16'(NULL_TIMEOUT - 1));

    // byte_cnt_q is the index of the byte currently held in TS_DATA
    always_comb begin
        hdr_byte = 8'h00;
        unique case (byte_cnt_q[1:0])
            2'd0:    hdr_byte = {1'b0, pusi_q, 1'b0, PID[12:8]};
            2'd1:    hdr_byte = PID[7:0];
            default: hdr_byte = {2'b00, 2'b01, cc_q};
        endcase
    end

`ifdef TS_NULL_FILL_EN
    logic [7:0] null_byte;

    always_comb begin
        null_byte = 8'hFF;
        unique case (byte_cnt_q)
            8'd0:    null_byte = 8'h1F;
            8'd2:    null_byte = 8'h10;
            default: null_byte = 8'hFF;
        endcase
    end
`endif

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        pusi_d     = pusi_q;
        byte_cnt_d = byte_cnt_q;
        cc_d       = cc_q;
        ts_data_d  = ts_data_q;
        ts_valid_d = ts_valid_q;
        ts_sop_d   = ts_sop_q;
        starve_d   = starve_q;
        up_ena     = 1'b0;

        unique case (state_q)
            StWait: begin
                // Step over upstream bubbles, freeze it on a valid byte
                up_ena = !ENA_IN;
                if (slot_free) begin
                    if (ENA_IN) begin
                        p_d        = POINTER_IN;
                        pusi_d     = (POINTER_IN <= 8'd182);
                        byte_cnt_d = 8'd0;
                        ts_data_d  = 8'h47;
                        ts_valid_d = 1'b1;
                        ts_sop_d   = 1'b1;
                        starve_d   = 16'd0;
                        state_d    = StHdr;
                    end else begin
                        ts_valid_d = 1'b0;
                        ts_sop_d   = 1'b0;
                        if (starve_hit) begin
`ifdef TS_NULL_FILL_EN
                            byte_cnt_d = 8'd0;
                            ts_data_d  = 8'h47;
                            ts_valid_d = 1'b1;
                            ts_sop_d   = 1'b1;
                            starve_d   = 16'd0;
                            state_d    = StNull;
`endif
                        end else begin
                            starve_d = starve_q + 16'd1;
                        end
                    end
                end
            end
            StHdr: begin
                if (slot_free) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    ts_data_d  = hdr_byte;
                    ts_valid_d = 1'b1;
                    ts_sop_d   = 1'b0;
                    if (byte_cnt_q == 8'd2) begin
                        cc_d    = cc_q + 4'd1;
                        state_d = pusi_q ? StPtr : StPay;
                    end
                end
            end
            StPtr: begin
                if (slot_free) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    ts_data_d  = p_q;
                    ts_valid_d = 1'b1;
                    ts_sop_d   = 1'b0;
                    state_d    = StPay;
                end
            end
            StPay: begin
                up_ena = slot_free;
                if (slot_free) begin
                    ts_sop_d = 1'b0;
                    if (ENA_IN) begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        ts_data_d  = DATA_IN;
                        ts_valid_d = 1'b1;
                        if (byte_cnt_q == 8'd186) begin
                            state_d = StWait;
                        end
                    end else begin
                        ts_valid_d = 1'b0;
                    end
                end
            end
`ifdef TS_NULL_FILL_EN
            StNull: begin
                if (slot_free) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    ts_data_d  = null_byte;
                    ts_valid_d = 1'b1;
                    ts_sop_d   = 1'b0;
                    if (byte_cnt_q == 8'd186) begin
                        state_d = StWait;
                    end
                end
            end
`endif
            default: state_d = StWait;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StWait;
            p_q        <= 8'h00;
            pusi_q     <= 1'b0;
            byte_cnt_q <= 8'd0;
            cc_q       <= 4'd0;
            ts_data_q  <= 8'h00;
            ts_valid_q <= 1'b0;
            ts_sop_q   <= 1'b0;
            starve_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            pusi_q     <= pusi_d;
            byte_cnt_q <= byte_cnt_d;
            cc_q       <= cc_d;
            ts_data_q  <= ts_data_d;
            ts_valid_q <= ts_valid_d;
            ts_sop_q   <= ts_sop_d;
            starve_q   <= starve_d;
        end
    end

    assign UP_ENA   = up_ena && !RST;
    assign TS_DATA  = ts_data_q;
    assign TS_VALID = ts_valid_q;
    assign TS_SOP   = ts_sop_q;
    assign cc_mon   = cc_q;

endmodule

// File: tb/tb_t2mi_to_ts_packer.sv
// Scoreboard bench for t2mi_to_ts_packer: a packet-level model of the expected TS stream
// is queued up front and compared byte by byte as the DUT transfers output.
module tb_t2mi_to_ts_packer;

    localparam logic [12:0] Pid       = 13'h1000;
    localparam int unsigned StreamLen = 8192;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] DATA_IN;
    logic       ENA_IN;
    logic [7:0] POINTER_IN;
    logic       UP_ENA;
    logic [7:0] TS_DATA;
    logic       TS_VALID;
    logic       TS_SOP;
    logic       OUT_READY;
    logic [3:0] cc_mon;

    always #5 clk = ~clk;

    t2mi_to_ts_packer #(
        .PID         (Pid),
        .NULL_TIMEOUT(16)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .DATA_IN   (DATA_IN),
        .ENA_IN    (ENA_IN),
        .POINTER_IN(POINTER_IN),
        .UP_ENA    (UP_ENA),
        .TS_DATA   (TS_DATA),
        .TS_VALID  (TS_VALID),
        .TS_SOP    (TS_SOP),
        .OUT_READY (OUT_READY),
        .cc_mon    (cc_mon)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] stream  [StreamLen];
    logic [7:0] ptr_mem [StreamLen];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         idx;
    int         midx;
    logic [3:0] mcc;
    bit         rdy_rand;
    bit         bub_rand;
    bit         idle;
    int         tcount;
    int         first_sop_t;
    int         last_xfer_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // T2-MI stream: fixed lengths first to hit P=0/17/183/0/255, then random lengths
    task automatic build_stream();
        int s;
        int len;
        int k;
        s = 0;
        k = 0;
        while (s < StreamLen) begin
            case (k)
                0:       len = 200;
                1:       len = 349;
                2:       len = 1;
                3:       len = 1000;
                default: len = 40 + int'($urandom_range(0, 500));
            endcase
            for (int i = 0; i < len && s + i < StreamLen; i++) begin
                stream[s+i]  = 8'($urandom);
                ptr_mem[s+i] = (i == 0) ? 8'd0 : ((len - i > 255) ? 8'd255 : 8'(len - i));
            end
            s += len;
            k++;
        end
    endtask

    task automatic push_data(input int n);
        logic [7:0] p;
        logic       pusi;
        int         cnt;
        for (int k = 0; k < n; k++) begin
            p    = ptr_mem[midx];
            pusi = (p <= 8'd182);
            cnt  = pusi ? 183 : 184;
            exp_q.push_back({8'h47, 1'b1});
            exp_q.push_back({1'b0, pusi, 1'b0, Pid[12:8], 1'b0});
            exp_q.push_back({Pid[7:0], 1'b0});
            exp_q.push_back({4'h1, mcc, 1'b0});
            if (pusi) exp_q.push_back({p, 1'b0});
            for (int j = 0; j < cnt; j++) exp_q.push_back({stream[midx+j], 1'b0});
            midx += cnt;
            mcc++;
        end
    endtask

    task automatic push_null();
        exp_q.push_back({8'h47, 1'b1});
        exp_q.push_back({8'h1F, 1'b0});
        exp_q.push_back({8'hFF, 1'b0});
        exp_q.push_back({8'h10, 1'b0});
        for (int j = 0; j < 184; j++) exp_q.push_back({8'hFF, 1'b0});
    endtask

    task automatic tick();
        exp_t e;
        logic cons;
        logic up_s;
        @(negedge clk);
        tcount++;
        if (TS_VALID && OUT_READY) begin
            if (TS_SOP && first_sop_t < 0) first_sop_t = tcount;
            last_xfer_t = tcount;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("ts_data", 32'(TS_DATA), 32'(e.data));
                check("ts_sop", 32'(TS_SOP), 32'(e.sop));
            end
        end
        if (TS_VALID && !OUT_READY && ENA_IN) check("up_ena_stall", 32'(UP_ENA), 32'd0);
        cons = UP_ENA && ENA_IN;
        up_s = UP_ENA;
        @(posedge clk);
        #1;
        if (cons && idx < StreamLen - 1) idx++;
        if (up_s) ENA_IN = idle ? 1'b0 : (bub_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        DATA_IN    = stream[idx];
        POINTER_IN = ptr_mem[idx];
        OUT_READY  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            tick();
            t++;
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset(input int ncyc);
        rst       = 1'b1;
        ENA_IN    = 1'b0;
        OUT_READY = 1'b1;
        idle      = 1'b0;
        rdy_rand  = 1'b0;
        bub_rand  = 1'b0;
        repeat (ncyc) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_valid", 32'(TS_VALID), 32'd0);
            check("rst_data", 32'(TS_DATA), 32'd0);
            check("rst_sop", 32'(TS_SOP), 32'd0);
            check("rst_cc", 32'(cc_mon), 32'd0);
            check("rst_up_ena", 32'(UP_ENA), 32'd0);
        end
        @(posedge clk);
        #1;
        rst         = 1'b0;
        idx         = 0;
        midx        = 0;
        mcc         = 4'd0;
        exp_q.delete();
        ENA_IN      = 1'b1;
        DATA_IN     = stream[0];
        POINTER_IN  = ptr_mem[0];
        tcount      = 0;
        first_sop_t = -1;
        last_xfer_t = -1;
    endtask

    initial begin
        rst        = 1'b1;
        DATA_IN    = 8'h00;
        POINTER_IN = 8'h00;
        ENA_IN     = 1'b0;
        OUT_READY  = 1'b1;
        build_stream();

        // 17 back-to-back packets, no stalls: CC wraps, full throughput
        do_reset(3);
        push_data(17);
        drain("p1", 17 * 188 + 50);
        check("p1_first_sop", 32'(first_sop_t), 32'd2);
        check("p1_last_xfer", 32'(last_xfer_t), 32'(17 * 188 + 1));
        check("p1_cc", 32'(cc_mon), 32'd1);

        // Random backpressure on the same stream
        do_reset(2);
        rdy_rand = 1'b1;
        push_data(6);
        drain("p2", 6000);

        // Random backpressure plus upstream bubbles
        do_reset(2);
        rdy_rand = 1'b1;
        bub_rand = 1'b1;
        push_data(6);
        drain("p3", 10000);

        // Reset at payload byte 100 abandons the packet, next one restarts at CC=0
        do_reset(2);
        push_data(1);
        while (tcount < 106) tick();
        check("mid_cc", 32'(cc_mon), 32'd1);
        do_reset(1);
        push_data(1);
        drain("p4", 400);
        check("p4_first_sop", 32'(first_sop_t), 32'd2);

`ifdef TS_NULL_FILL_EN
        // Upstream idle: one null packet after 16 starved cycles, CC not advanced
        do_reset(2);
        ENA_IN = 1'b0;
        idle   = 1'b1;
        push_null();
        push_data(1);
        repeat (20) tick();
        idle = 1'b0;
        drain("null", 800);
        check("null_first_sop", 32'(first_sop_t), 32'd17);
        check("null_cc", 32'(cc_mon), 32'd1);
`else
        // Upstream idle: WAIT stalls with no output
        do_reset(2);
        ENA_IN = 1'b0;
        idle   = 1'b1;
        repeat (40) begin
            tick();
            check("stall_valid", 32'(TS_VALID), 32'd0);
        end
        idle = 1'b0;
        push_data(1);
        drain("stall", 400);
        check("stall_cc", 32'(cc_mon), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
